vga_pixel_pipe: RTL

//  Pixel-generation stage fed by the registered sync block's pixel_x/pixel_y.

---
 rtl/vga_pixel_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - 4-clk background/sprite pixel pipeline with chroma key
// Define SPRITE_FLIP_EN to enable horizontal sprite mirroring via sprite_flip.
module vga_pixel_pipe #(
   parameter int          SPR_W   = 32,
   parameter int          SPR_H   = 32,
   parameter logic [11:0] CHROMA  = 12'h0F0,
   parameter int          LATCH_Y = 480,
   localparam int         AW      = $clog2(SPR_W * SPR_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic [9:0]    sprite_x,
   input  logic [9:0]    sprite_y,
   input  logic          sprite_flip,
   output logic [16:0]   bg_addr,
   input  logic [11:0]   bg_data,
   output logic [AW-1:0] spr_addr,
   input  logic [11:0]   spr_data,
   output logic          frame_tick,
   output logic [11:0]   rgb
);

   logic [9:0]    prev_y;
   logic [9:0]    sx;
   logic [9:0]    sy;
   logic          latch;
   logic [10:0]   dx;
   logic [10:0]   dy;
   logic [9:0]    dx_eff;
   logic          in_spr;
   logic          on_scr;
   logic [16:0]   y_half;
   logic [16:0]   x_half;
   logic [16:0]   bg_lin;
   logic [AW-1:0] spr_lin;

   logic          s1_in_spr;
   logic          s1_on_scr;
   logic [11:0]   s2_bg;
   logic [11:0]   s2_spr;
   logic          s2_in_spr;
   logic          s2_on_scr;
   logic [11:0]   s3_pix;
   logic          s3_on_scr;

   // Sprite position is only sampled on entry to the first vblank line, so it never tears.
   assign latch = (pixel_y == 10'(LATCH_Y)) && (prev_y != 10'(LATCH_Y));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_y     <= '0;
         sx         <= '0;
         sy         <= '0;
         frame_tick <= 1'b0;
      end else begin
         prev_y     <= pixel_y;
         frame_tick <= latch;
         if (latch) begin
            sx <= sprite_x;
            sy <= sprite_y;
         end
      end
   end

`ifdef SPRITE_FLIP_EN
   logic flip;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         flip <= 1'b0;
      else if (latch)
         flip <= sprite_flip;
   end

   assign dx_eff = flip ? (10'(SPR_W - 1) - dx[9:0]) : dx[9:0];
`else
   logic unused_flip;
   assign unused_flip = sprite_flip;
   assign dx_eff      = dx[9:0];
`endif

   // Zero-extended subtraction: bit 10 set means the pixel is left of / above the sprite.
   assign dx     = {1'b0, pixel_x} - {1'b0, sx};
   assign dy     = {1'b0, pixel_y} - {1'b0, sy};
   assign in_spr = !dx[10] && (dx[9:0] < 10'(SPR_W)) &&
                   !dy[10] && (dy[9:0] < 10'(SPR_H));
   assign on_scr = (pixel_x < 10'd640) && (pixel_y < 10'd480);

   // y*320 as (y<<8)+(y<<6) on the half-resolution coordinates.
   assign y_half  = {8'd0, pixel_y[9:1]};
   assign x_half  = {8'd0, pixel_x[9:1]};
   assign bg_lin  = (y_half << 8) + (y_half << 6) + x_half;
   assign spr_lin = AW'(dy[9:0]) * AW'(SPR_W) + AW'(dx_eff);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bg_addr   <= '0;
         spr_addr  <= '0;
         s1_in_spr <= 1'b0;
         s1_on_scr <= 1'b0;
         s2_bg     <= '0;
         s2_spr    <= '0;
         s2_in_spr <= 1'b0;
         s2_on_scr <= 1'b0;
         s3_pix    <= '0;
         s3_on_scr <= 1'b0;
         rgb       <= '0;
      end else begin
         bg_addr   <= on_scr ? bg_lin : 17'd0;
         spr_addr  <= in_spr ? spr_lin : '0;
         s1_in_spr <= in_spr;
         s1_on_scr <= on_scr;

         s2_bg     <= bg_data;
         s2_spr    <= spr_data;
         s2_in_spr <= s1_in_spr;
         s2_on_scr <= s1_on_scr;

         s3_pix    <= (s2_in_spr && (s2_spr != CHROMA)) ? s2_spr : s2_bg;
         s3_on_scr <= s2_on_scr;

         rgb       <= s3_on_scr ? s3_pix : 12'h000;
      end
   end

endmodule
